// File: rtl/inst_queue_pkg.sv
// Shared constants for the IF->ID instruction queue: bus widths, the
// bubble instruction and the address reported with it.
package inst_queue_pkg;

    localparam int INST_DATA_BUS = 32;
    localparam int INST_ADDR_BUS = 32;

    // addi x0, x0, 0 -- the canonical bubble decode sees when nothing is queued
    localparam logic [31:0] INS_NOP    = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/inst_queue.sv
// IF->ID instruction queue: a DEPTH-entry circular buffer of
// {instruction, address} pairs with valid/ready on both sides.
// Optional build macro: INST_QUEUE_BYPASS_EN (zero-latency path when empty).
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = INST_DATA_BUS,
    parameter int ADDR_W = INST_ADDR_BUS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [DATA_W-1:0]        ins_i,
    input  logic [ADDR_W-1:0]        ins_addr_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [DATA_W-1:0]        ins_o,
    output logic [ADDR_W-1:0]        ins_addr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("inst_queue: DEPTH must be a power of two and at least 2");
    end
    if ((DATA_W < 1) || (ADDR_W < 1)) begin : g_width_chk
        $error("inst_queue: DATA_W and ADDR_W must be positive");
    end

    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic [DATA_W-1:0] ins_mem_q  [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];

    logic full_w, empty_w, push_w, pop_w;
    logic byp_show_w, byp_take_w;

    // Pointers carry one extra wrap bit, so equal index with differing wrap bit means full
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

`ifdef INST_QUEUE_BYPASS_EN
    // An empty queue forwards the fetch word straight to decode; if decode takes it, it is never stored
    assign byp_show_w = empty_w & s_valid_i & ~flush_i;
    assign byp_take_w = byp_show_w & m_ready_i;
`else
    assign byp_show_w = 1'b0;
    assign byp_take_w = 1'b0;
`endif

    // Ready looks only at registered state, so a full queue refuses input even while it pops
    assign s_ready_o = ~full_w;
    assign push_w    = s_valid_i & s_ready_o & ~flush_i & ~byp_take_w;
    assign pop_w     = ~empty_w & m_ready_i & ~flush_i;

    assign m_valid_o  = ~empty_w | byp_show_w;
    assign count_o    = count_q;
    assign ins_o      = !empty_w   ? ins_mem_q[rd_ptr_q[PW-1:0]]  :
                        byp_show_w ? ins_i                        : DATA_W'(INS_NOP);
    assign ins_addr_o = !empty_w   ? addr_mem_q[rd_ptr_q[PW-1:0]] :
                        byp_show_w ? ins_addr_i                   : ADDR_W'(RESET_ADDR);

    // Next pointer/count values; flush dominates and returns everything to zero
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (pop_w)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, the only reset state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; unreset because reads are masked while empty
    always_ff @(posedge clk) begin
        if (push_w) begin
            ins_mem_q[wr_ptr_q[PW-1:0]]  <= ins_i;
            addr_mem_q[wr_ptr_q[PW-1:0]] <= ins_addr_i;
        end
    end

    // Guard against overflow/underflow ever slipping through the handshake logic
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_w && full_w))  else $error("inst_queue: push while full");
            assert (!(pop_w && empty_w))  else $error("inst_queue: pop while empty");
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios followed by random traffic, all
// checked every cycle against a queue-based reference model.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, s_valid_i, s_ready_o, m_valid_o, m_ready_i;
    logic [31:0] ins_i, ins_addr_i, ins_o, ins_addr_o;
    logic [2:0]  count_o;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] addr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] consumed[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    inst_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .ins_i      (ins_i),
        .ins_addr_i (ins_addr_i),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .ins_o      (ins_o),
        .ins_addr_o (ins_addr_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, m_valid_o, 0);
        chk({tag, "_ready"}, s_ready_o, 1);
        chk({tag, "_count"}, count_o, 0);
        chk({tag, "_ins"},   ins_o, INS_NOP);
        chk({tag, "_addr"},  ins_addr_o, RESET_ADDR);
    endtask

    // One cycle: drive at negedge, compare before the edge, then advance the model
    task automatic step(input logic sv, input logic [31:0] ins, input logic [31:0] addr,
                        input logic mr, input logic fl);
        bit   byp, ev, do_push, do_pop;
        ent_t head;
        int   sz;
        @(negedge clk);
        s_valid_i = sv; ins_i = ins; ins_addr_i = addr; m_ready_i = mr; flush_i = fl;
        #1;
        sz  = q.size();
        byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp = (sz == 0) && sv && !fl;
`endif
        if (sz != 0)  head = q[0];
        else if (byp) head = '{ins, addr};
        else          head = '{INS_NOP, RESET_ADDR};
        ev = (sz != 0) || byp;
        chk("m_valid", m_valid_o, ev);
        chk("s_ready", s_ready_o, sz < DEPTH);
        chk("count",   count_o, sz);
        chk("ins",     ins_o, head.ins);
        chk("addr",    ins_addr_o, head.addr);
        do_pop  = (sz != 0) && mr && !fl;
        do_push = sv && (sz < DEPTH) && !fl && !(byp && mr);
        if (ev && mr && !fl) consumed.push_back(head.addr);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back('{ins, addr});
        end
    endtask

    initial begin
        logic [31:0] exp_order[4];
        rst_n = 1'b0; flush_i = 0; s_valid_i = 0; m_ready_i = 0; ins_i = 0; ins_addr_i = 0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full with decode stalled; a fifth push must be dropped
        step(1, 32'h0000_0013, 32'h0, 0, 0);
        step(1, 32'h0010_0093, 32'h4, 0, 0);
        step(1, 32'h0020_0113, 32'h8, 0, 0);
        step(1, 32'h0030_0193, 32'hC, 0, 0);
        step(1, 32'hDEAD_BEEF, 32'h40, 0, 0);
        #1;
        chk("fill_count", count_o, 4);
        chk("fill_ready", s_ready_o, 0);
        chk("fill_head",  ins_addr_o, 32'h0);

        // Drain two, refill two across the wrap, then drain everything
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        consumed.delete();
        step(1, 32'h0000_00AA, 32'h10, 0, 0);
        step(1, 32'h0000_00BB, 32'h14, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        exp_order = '{32'h8, 32'hC, 32'h10, 32'h14};
        chk("wrap_n", consumed.size(), 4);
        for (int i = 0; i < 4 && i < consumed.size(); i++) chk("wrap_order", consumed[i], exp_order[i]);

        // Simultaneous push and pop at two entries
        step(1, 32'h1111_0001, 32'h100, 0, 0);
        step(1, 32'h1111_0002, 32'h104, 0, 0);
        consumed.delete();
        step(1, 32'h1111_0003, 32'h108, 1, 0);
        step(1, 32'h1111_0004, 32'h10C, 1, 0);
        #1;
        chk("pp_count", count_o, 2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk("pp_first", consumed.size() > 0 ? consumed[0] : 32'hFFFF_FFFF, 32'h100);
        chk("pp_last",  consumed.size() > 3 ? consumed[3] : 32'hFFFF_FFFF, 32'h10C);

        // Flush at three entries with a live input
        step(1, 32'h2222_0001, 32'h200, 0, 0);
        step(1, 32'h2222_0002, 32'h204, 0, 0);
        step(1, 32'h2222_0003, 32'h208, 0, 0);
        step(1, 32'h2222_0004, 32'h20C, 1, 1);
        #1;
        chk_reset_outputs("flush");
        step(0, 0, 0, 1, 0);

        // Empty queue, fetch and decode both active
        step(1, 32'h0040_006F, 32'h20, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Asynchronous reset mid-operation
        step(1, 32'h3333_0001, 32'h300, 0, 0);
        step(1, 32'h3333_0002, 32'h304, 0, 0);
        @(negedge clk);
        s_valid_i = 0; m_ready_i = 0; flush_i = 0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 500; i++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
